// File: rtl/tcdm_demux_ot.sv
// Routes one TCDM master to NR_OUTPUTS slaves by address rule, with an internal error responder.
// Request path is combinational; stalls while full or while responses are pending on a different target.
module tcdm_demux_ot #(
  parameter int unsigned NR_OUTPUTS      = 3,
  parameter int unsigned NR_ADDR_RULES   = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] ERROR_RESPONSE  = 32'hBADACCE5,
  localparam int unsigned IDX_W = (NR_OUTPUTS > 1) ? $clog2(NR_OUTPUTS) : 1,
  localparam int unsigned BE_W  = DATA_WIDTH / 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NR_ADDR_RULES*IDX_W-1:0]      rule_idx_i,
  input  logic [NR_ADDR_RULES*ADDR_WIDTH-1:0] rule_start_i,
  input  logic [NR_ADDR_RULES*ADDR_WIDTH-1:0] rule_end_i,
  input  logic                                m_req_i,
  input  logic [ADDR_WIDTH-1:0]               m_add_i,
  input  logic                                m_wen_i,
  input  logic [DATA_WIDTH-1:0]               m_wdata_i,
  input  logic [BE_W-1:0]                     m_be_i,
  output logic                                m_gnt_o,
  output logic                                m_r_valid_o,
  output logic [DATA_WIDTH-1:0]               m_r_rdata_o,
  output logic                                m_r_opc_o,
  output logic [NR_OUTPUTS-1:0]               s_req_o,
  output logic [NR_OUTPUTS*ADDR_WIDTH-1:0]    s_add_o,
  output logic [NR_OUTPUTS-1:0]               s_wen_o,
  output logic [NR_OUTPUTS*DATA_WIDTH-1:0]    s_wdata_o,
  output logic [NR_OUTPUTS*BE_W-1:0]          s_be_o,
  input  logic [NR_OUTPUTS-1:0]               s_gnt_i,
  input  logic [NR_OUTPUTS-1:0]               s_r_valid_i,
  input  logic [NR_OUTPUTS-1:0]               s_r_opc_i,
  input  logic [NR_OUTPUTS*DATA_WIDTH-1:0]    s_r_rdata_i
);

  localparam int unsigned CNT_W = (MAX_OUTSTANDING > 0) ? $clog2(MAX_OUTSTANDING + 1) : 1;
  localparam logic [IDX_W:0]        ERR_PORT = (IDX_W + 1)'(NR_OUTPUTS);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERROR_RESPONSE);
  localparam logic [CNT_W-1:0]      OT_MAX   = CNT_W'(MAX_OUTSTANDING);

  logic [IDX_W:0]   act_q;
  logic [CNT_W-1:0] ot_q, ot_d;
  logic             err_pend_q, err_rd_q;

  logic [IDX_W:0]   sel;
  logic [IDX_W-1:0] sel_idx, act_idx;
  logic             hit, sel_err, acc, hs, rsp_vld;

  // Lowest-numbered matching rule wins; out-of-range targets fall through to the error port.
  always_comb begin
    sel = ERR_PORT;
    hit = 1'b0;
    for (int i = 0; i < NR_ADDR_RULES; i++) begin
      if (!hit && m_add_i >= rule_start_i[i*ADDR_WIDTH +: ADDR_WIDTH]
               && m_add_i <  rule_end_i[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = 1'b1;
        if ({1'b0, rule_idx_i[i*IDX_W +: IDX_W]} < ERR_PORT) sel = {1'b0, rule_idx_i[i*IDX_W +: IDX_W]};
      end
    end
  end

  assign sel_idx = sel[IDX_W-1:0];
  assign act_idx = act_q[IDX_W-1:0];
  assign sel_err = (sel == ERR_PORT);
  assign acc     = !rst_i && m_req_i && (ot_q < OT_MAX) && ((ot_q == '0) || (sel == act_q));

  always_comb begin
    s_req_o = '0;
    m_gnt_o = 1'b0;
    if (acc) begin
      if (sel_err) begin
        m_gnt_o = 1'b1;
      end else begin
        s_req_o[sel_idx] = 1'b1;
        m_gnt_o          = s_gnt_i[sel_idx];
      end
    end
  end

  assign s_add_o   = rst_i ? '0 : {NR_OUTPUTS{m_add_i}};
  assign s_wen_o   = rst_i ? '0 : {NR_OUTPUTS{m_wen_i}};
  assign s_wdata_o = rst_i ? '0 : {NR_OUTPUTS{m_wdata_i}};
  assign s_be_o    = rst_i ? '0 : {NR_OUTPUTS{m_be_i}};

  // Responses are only taken from the active target and only while something is in flight.
  always_comb begin
    rsp_vld     = 1'b0;
    m_r_rdata_o = '0;
    m_r_opc_o   = 1'b0;
    if (!rst_i && ot_q != '0) begin
      if (act_q == ERR_PORT) begin
        rsp_vld = err_pend_q;
        if (err_pend_q) begin
          m_r_opc_o   = 1'b1;
          m_r_rdata_o = err_rd_q ? ERR_DATA : '0;
        end
      end else if (s_r_valid_i[act_idx]) begin
        rsp_vld     = 1'b1;
        m_r_opc_o   = s_r_opc_i[act_idx];
        m_r_rdata_o = s_r_rdata_i[act_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign m_r_valid_o = rsp_vld;
  assign hs          = m_req_i && m_gnt_o;

  always_comb begin
    ot_d = ot_q;
    if (hs && !rsp_vld)      ot_d = ot_q + 1'b1;
    else if (!hs && rsp_vld) ot_d = ot_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_q      <= '0;
      ot_q       <= '0;
      err_pend_q <= 1'b0;
      err_rd_q   <= 1'b0;
    end else begin
      ot_q       <= ot_d;
      err_pend_q <= hs && sel_err;
      if (hs) act_q <= sel;
      if (hs && sel_err) err_rd_q <= m_wen_i;
    end
  end

`ifndef SYNTHESIS
  logic [NR_OUTPUTS-1:0] own_mask;
  always_comb begin
    own_mask = '0;
    if (act_q != ERR_PORT) own_mask[act_idx] = 1'b1;
  end

  // A slave answering while another target owns the response path is a protocol violation.
  always @(posedge clk_i) begin
    if (!rst_i && ot_q != '0) assert ((s_r_valid_i & ~own_mask) == '0);
  end
`endif

endmodule

// File: tb/tb_tcdm_demux_ot.sv
// Randomized and directed bench for tcdm_demux_ot against a queue-based transaction model.
module tb_tcdm_demux_ot;

  localparam int NO = 3;
  localparam int ERR = NO;
  localparam int MAXO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  rule_idx_i;
  logic [63:0] rule_start_i, rule_end_i;
  logic        m_req_i, m_wen_i;
  logic [31:0] m_add_i, m_wdata_i;
  logic [3:0]  m_be_i;
  logic        m_gnt_o, m_r_valid_o, m_r_opc_o;
  logic [31:0] m_r_rdata_o;
  logic [NO-1:0]    s_req_o, s_wen_o, s_gnt_i, s_r_valid_i, s_r_opc_i;
  logic [NO*32-1:0] s_add_o, s_wdata_o, s_r_rdata_i;
  logic [NO*4-1:0]  s_be_o;

  tcdm_demux_ot dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rule_idx_i(rule_idx_i), .rule_start_i(rule_start_i), .rule_end_i(rule_end_i),
    .m_req_i(m_req_i), .m_add_i(m_add_i), .m_wen_i(m_wen_i), .m_wdata_i(m_wdata_i), .m_be_i(m_be_i),
    .m_gnt_o(m_gnt_o), .m_r_valid_o(m_r_valid_o), .m_r_rdata_o(m_r_rdata_o), .m_r_opc_o(m_r_opc_o),
    .s_req_o(s_req_o), .s_add_o(s_add_o), .s_wen_o(s_wen_o), .s_wdata_o(s_wdata_o), .s_be_o(s_be_o),
    .s_gnt_i(s_gnt_i), .s_r_valid_i(s_r_valid_i), .s_r_opc_i(s_r_opc_i), .s_r_rdata_i(s_r_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int port; int due; logic [31:0] data; logic opc; } rsp_t;

  logic [1:0]  r_idx[2];
  logic [31:0] r_start[2], r_end[2];
  assign rule_idx_i   = {r_idx[1], r_idx[0]};
  assign rule_start_i = {r_start[1], r_start[0]};
  assign rule_end_i   = {r_end[1], r_end[0]};

  int   checks = 0, errors = 0;
  int   cyc = 0, cur_tgt = 0, rv_seen = 0;
  int   lat[NO];
  rsp_t exp_q[$];
  rsp_t slv_q[$];
  logic last_hs, d_gnt, d_rv, d_opc;
  logic [NO-1:0] d_sreq, d_srv;
  logic [31:0]   d_rdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 2; i++)
      if (a >= r_start[i] && a < r_end[i]) return (int'(r_idx[i]) < NO) ? int'(r_idx[i]) : ERR;
    return ERR;
  endfunction

  function automatic logic [31:0] sdata(input logic [31:0] a);
    return a ^ 32'hD6FEF01D;
  endfunction

  task automatic drive_slaves();
    s_r_valid_i = '0; s_r_rdata_i = '0; s_r_opc_i = '0;
    for (int i = 0; i < slv_q.size();) begin
      if (slv_q[i].due == cyc) begin
        s_r_valid_i[slv_q[i].port]            = 1'b1;
        s_r_opc_i[slv_q[i].port]              = slv_q[i].opc;
        s_r_rdata_i[slv_q[i].port*32 +: 32]   = slv_q[i].data;
        slv_q.delete(i);
      end else i++;
    end
  endtask

  // One clock: compare DUT against the transaction model at negedge, then advance.
  task automatic cycle();
    int tgt; logic acc, e_gnt, e_rv, bc; logic [NO-1:0] e_sreq; rsp_t e;
    @(negedge clk_i);
    tgt   = decode(m_add_i);
    acc   = m_req_i && exp_q.size() < MAXO && (exp_q.size() == 0 || tgt == cur_tgt);
    e_sreq = '0; e_gnt = 1'b0;
    if (acc) begin
      if (tgt == ERR) e_gnt = 1'b1;
      else begin e_sreq[tgt] = 1'b1; e_gnt = s_gnt_i[tgt]; end
    end
    e_rv = exp_q.size() > 0 && exp_q[0].due == cyc;
    d_gnt = m_gnt_o; d_sreq = s_req_o; d_rv = m_r_valid_o; d_rdata = m_r_rdata_o;
    d_opc = m_r_opc_o; d_srv = s_r_valid_i;
    if (d_rv) rv_seen++;
    chk("m_gnt", m_gnt_o, e_gnt);
    chk("s_req", s_req_o, e_sreq);
    chk("r_valid", m_r_valid_o, e_rv);
    if (e_rv) begin
      chk("r_rdata", m_r_rdata_o, exp_q[0].data);
      chk("r_opc", m_r_opc_o, exp_q[0].opc);
    end
    bc = (s_add_o === {NO{m_add_i}}) && (s_wdata_o === {NO{m_wdata_i}}) &&
         (s_wen_o === {NO{m_wen_i}}) && (s_be_o === {NO{m_be_i}});
    chk("broadcast", bc, 1'b1);
    for (int p = 0; p < NO; p++)
      if (s_req_o[p] && s_gnt_i[p]) begin
        e.port = p; e.due = cyc + lat[p]; e.data = sdata(m_add_i); e.opc = m_add_i[3];
        slv_q.push_back(e);
      end
    if (e_rv) void'(exp_q.pop_front());
    last_hs = m_req_i && e_gnt;
    if (last_hs) begin
      e.port = tgt;
      e.due  = cyc + ((tgt == ERR) ? 1 : lat[tgt]);
      e.data = (tgt == ERR) ? (m_wen_i ? 32'hBADACCE5 : 32'h0) : sdata(m_add_i);
      e.opc  = (tgt == ERR) ? 1'b1 : m_add_i[3];
      exp_q.push_back(e);
      cur_tgt = tgt;
    end
    @(posedge clk_i); #1;
    cyc++;
    drive_slaves();
  endtask

  task automatic drain();
    m_req_i = 1'b0; s_gnt_i = '1;
    for (int i = 0; i < 60 && (exp_q.size() + slv_q.size()) > 0; i++) cycle();
    chk("drain", exp_q.size() + slv_q.size(), 0);
  endtask

  task automatic req(input logic [31:0] a, input logic wen);
    m_req_i = 1'b1; m_add_i = a; m_wen_i = wen; m_wdata_i = $urandom; m_be_i = 4'hF;
  endtask

  function automatic logic [31:0] rnd_addr();
    int k; k = $urandom_range(0, 1);
    case ($urandom_range(0, 5))
      0, 1:    return r_start[k] + $urandom_range(0, int'(r_end[k] - r_start[k]) - 1);
      2:       return r_start[k];
      3:       return r_end[k] - 1;
      4:       return r_end[k];
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int gc[$]; int exp_gc[6]; int t0, g, n, base;
    exp_gc = '{0, 1, 2, 3, 6, 7};
    r_idx[0] = 2'd1; r_start[0] = 32'h1C000000; r_end[0] = 32'h1C080000;
    r_idx[1] = 2'd0; r_start[1] = 32'h1A100000; r_end[1] = 32'h1A200000;
    lat = '{1, 3, 1};
    rst_i = 1'b1; s_gnt_i = '1; s_r_valid_i = '0; s_r_opc_i = '0; s_r_rdata_i = '0;
    m_wdata_i = '0; m_be_i = '0; last_hs = 1'b0;
    req(32'h1C000010, 1'b1);
    #1;
    chk("pin_dec_r0", decode(32'h1C000010), 1);
    chk("pin_dec_r1", decode(32'h1A1FFFFC), 0);
    chk("pin_dec_end", decode(32'h1C080000), ERR);
    chk("pin_sdata", sdata(32'h1C000010), 32'hCAFEF00D);
    chk("rst_gnt", m_gnt_o, 0);
    chk("rst_sreq", s_req_o, 0);
    chk("rst_rvalid", m_r_valid_o, 0);
    repeat (2) @(posedge clk_i);
    #1; rst_i = 1'b0; m_req_i = 1'b0;

    // Read through port 1, latency 3.
    req(32'h1C000010, 1'b1); cycle();
    chk("t1_sreq", d_sreq, 3'b010); chk("t1_gnt", d_gnt, 1);
    m_req_i = 1'b0; cycle(); chk("t1_rv1", d_rv, 0);
    cycle(); chk("t1_rv2", d_rv, 0);
    cycle(); chk("t1_rv3", d_rv, 1); chk("t1_data", d_rdata, 32'hCAFEF00D);
    drain();

    // Unmapped read then write back-to-back through the error responder.
    req(32'h00000004, 1'b1); cycle(); chk("t2_gnt", d_gnt, 1); chk("t2_sreq", d_sreq, 0);
    req(32'h00000004, 1'b0); cycle();
    chk("t2_rd_rv", d_rv, 1); chk("t2_rd_data", d_rdata, 32'hBADACCE5); chk("t2_rd_opc", d_opc, 1);
    m_req_i = 1'b0; cycle();
    chk("t2_wr_rv", d_rv, 1); chk("t2_wr_data", d_rdata, 0); chk("t2_wr_opc", d_opc, 1);
    drain();

    // Six back-to-back reads to port 0, latency 5: fills to MAX_OUTSTANDING.
    lat[0] = 5; t0 = cyc; n = 0; base = rv_seen;
    for (int i = 0; i < 30 && n < 6; i++) begin
      req(32'h1A100000 + 4 * n, 1'b1);
      g = cyc - t0; cycle();
      if (d_gnt) begin gc.push_back(g); n++; end
    end
    drain();
    chk("t3_ngrants", gc.size(), 6);
    for (int i = 0; i < 6; i++) if (i < gc.size()) chk("t3_grant_cyc", gc[i], exp_gc[i]);
    chk("t3_rsp_count", rv_seen - base, 6);

    // Target switch waits for the previous target to go quiet.
    lat[1] = 4; t0 = cyc; g = -1;
    req(32'h1C000020, 1'b1); cycle();
    for (int i = 0; i < 20 && g < 0; i++) begin
      req(32'h1A100040, 1'b1); cycle();
      if (d_gnt) g = cyc - 1 - t0;
      else chk("t4_no_leak", d_sreq, 0);
    end
    chk("t4_switch_cyc", g, 5);
    drain();

    // Steady handshake+response overlap must not creep the outstanding count.
    lat[0] = 2;
    for (int i = 0; i < 8; i++) begin
      req(32'h1A100100 + 4 * i, 1'b1); cycle(); chk("t5_gnt", d_gnt, 1);
    end
    drain();

    // Reset with three reads in flight; late slave answers must be dropped.
    lat[1] = 6;
    for (int i = 0; i < 3; i++) begin req(32'h1C000100 + 4 * i, 1'b1); cycle(); end
    rst_i = 1'b1; req(32'h1C000200, 1'b1); #1;
    chk("t6_gnt", m_gnt_o, 0); chk("t6_sreq", s_req_o, 0); chk("t6_rv", m_r_valid_o, 0);
    repeat (2) begin
      @(posedge clk_i); #1; cyc++; drive_slaves();
      chk("t6_rst_gnt", m_gnt_o, 0); chk("t6_rst_rv", m_r_valid_o, 0);
    end
    rst_i = 1'b0; m_req_i = 1'b0; exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (d_srv[1]) chk("t6_late_dropped", d_rv, 0);
    end
    drain();

    // Randomized phases with different maps and latencies.
    for (int ph = 0; ph < 3; ph++) begin
      case (ph)
        0: begin lat = '{1, 2, 3}; end
        1: begin
          r_idx[0] = 2'd3; r_start[0] = 32'h1000; r_end[0] = 32'h2000;
          r_idx[1] = 2'd2; r_start[1] = 32'h0;    r_end[1] = 32'h3000;
          lat = '{3, 1, 1};
        end
        default: begin
          r_idx[0] = 2'd0; r_start[0] = 32'h100; r_end[0] = 32'h200;
          r_idx[1] = 2'd2; r_start[1] = 32'h180; r_end[1] = 32'h400;
          lat = '{1, 4, 2};
        end
      endcase
      m_req_i = 1'b0; last_hs = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if (!m_req_i || last_hs) begin
          if ($urandom_range(0, 99) < 65) begin
            req(rnd_addr(), 1'($urandom)); m_be_i = 4'($urandom);
          end else m_req_i = 1'b0;
        end
        for (int p = 0; p < NO; p++) s_gnt_i[p] = ($urandom_range(0, 99) < 70);
        cycle();
      end
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcdm_demux_ot.md
Name: tcdm_demux_ot

Overview:
Parametrised successor to the L2 TCDM demultiplexer. It routes one TCDM master port to NR_OUTPUTS TCDM slave ports by address rules. It supports slaves with variable latency (one cycle or more) and up to MAX_OUTSTANDING in-flight transactions. Unmapped addresses are answered by an internal error responder. It sits between each SoC master port and the interleaved, contiguous and AXI-bridge paths.

Parameters:
NR_OUTPUTS, 3, number of slave ports (>=1)
NR_ADDR_RULES, 2, number of address map rules (>=1)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; BE width = DATA_WIDTH/8
MAX_OUTSTANDING, 4, maximum in-flight transactions (>=1)
ERROR_RESPONSE, 32'hBADACCE5, read data returned for unmapped accesses (zero-extended/truncated to DATA_WIDTH)
IDX_W (local), max(1,$clog2(NR_OUTPUTS)), port index width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
rule_idx_i  in  NR_ADDR_RULES*IDX_W  target port per rule
rule_start_i  in  NR_ADDR_RULES*ADDR_WIDTH  inclusive start address per rule
rule_end_i  in  NR_ADDR_RULES*ADDR_WIDTH  exclusive end address per rule
m_req_i / m_add_i / m_wen_i / m_wdata_i / m_be_i  in  1/ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8  master request; wen=1 means read
m_gnt_o  out  1  grant
m_r_valid_o / m_r_rdata_o / m_r_opc_o  out  1/DATA_WIDTH/1  master response
s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o  out  NR_OUTPUTS x same widths  slave requests
s_gnt_i, s_r_valid_i, s_r_opc_i  in  NR_OUTPUTS each  slave grant and response flags
s_r_rdata_i  in  NR_OUTPUTS*DATA_WIDTH  slave read data

Behaviour:
- Decode (combinational): the lowest-numbered rule with start<=addr<end wins. A rule index >=NR_OUTPUTS, or no match, selects the internal error port (ERR).
- State: act_port (IDX_W+1 bits, NR_OUTPUTS encodes ERR), ot_cnt (0..MAX_OUTSTANDING), err_pend, err_rd. Reset: all 0. Every output is 0 during and after reset until a new request arrives.
- Accept condition acc = m_req_i & (ot_cnt<MAX_OUTSTANDING) & (ot_cnt==0 | sel==act_port).
  - When accepted for a real port: s_req_o[sel]=1 and m_gnt_o=s_gnt_i[sel].
  - When accepted for ERR: m_gnt_o=1.
  - Otherwise all s_req_o=0 and m_gnt_o=0 (stall; no request leaks to a different port while responses are pending there).
- s_add/wen/wdata/be are broadcast to all ports; only s_req_o is gated.
- On handshake (m_req_i & m_gnt_o): act_port<=sel, ot_cnt++.
- Response: m_r_valid_o = s_r_valid_i[act_port] (or err_pend for ERR), with rdata/opc muxed from the same source. ot_cnt-- on each response while ot_cnt>0. A handshake and a response in the same cycle leave ot_cnt unchanged.
- Responses from non-active ports, or any response while ot_cnt==0, are dropped; a simulation assertion flags them.
- Error responder: a handshake to ERR sets err_pend for exactly the next cycle. The response carries m_r_opc_o=1 and m_r_rdata_o=ERROR_RESPONSE for reads, 0 for writes. Back-to-back ERR accesses give back-to-back responses (fixed latency 1).
- Full: at ot_cnt==MAX_OUTSTANDING, m_gnt_o=0 even when a response retires in the same cycle. No combinational path from r_valid to gnt.
- Ordering: responses are returned in issue order, guaranteed because only one target is outstanding at a time.
- Reset mid-operation clears ot_cnt and err_pend. Late slave responses after reset are dropped (ot_cnt==0).
- Rule inputs are quasi-static; changing them while ot_cnt>0 does not affect the routing of in-flight responses.

Test Plan:
- Rules {0x1C000000-0x1C080000 -> 1, 0x1A100000-0x1A200000 -> 0}. Read at 0x1C000010 with slave 1 at latency 3 -> s_req_o=3'b010, gnt same cycle, m_r_valid_o 3 cycles later with slave data 0xCAFEF00D.
- Read at 0x00000004 (unmapped) -> m_gnt_o=1 same cycle; next cycle m_r_valid_o=1, rdata=0xBADACCE5, opc=1. A write to the same address -> opc=1, rdata=0.
- MAX_OUTSTANDING=4, slave 0 always granting, latency 5; 6 back-to-back reads -> first 4 granted, gnt low until the first response, then 1 more per response; 6 responses in order.
- Read to port 1 outstanding, then request to port 0 -> no s_req_o[0] and m_gnt_o=0 until port-1 response; port-0 grant the cycle after ot_cnt reaches 0.
- Handshake and response in the same cycle at ot_cnt=2 -> ot_cnt stays 2; gnt stays available.
- Assert rst_i with 3 outstanding -> outputs 0 immediately; a subsequent s_r_valid_i[1] pulse produces no m_r_valid_o.
